gate_seq_ctrl: RTL and testbench



---
 rtl/gate_seq_ctrl.sv | 120 ++++++++++++
 tb/tb_gate_seq_ctrl.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gate_seq_ctrl.sv
// Self-test sequencer for the 2-input, 6-function gate datapath.
// Optional macro GATE_SEQ_LOOP_EN: Start held in DONE re-runs the sweep with flags accumulating.
module gate_seq_ctrl #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       Start,
    output logic [1:0] Gate_In,
    input  logic [5:0] Gate_Out,
    output logic       Busy,
    output logic       Done,
    output logic       Pass,
    output logic [5:0] Err_Mask,
    output logic [1:0] Err_Vec,
    output logic [1:0] dbg_state
);

    // Start is a level request with no ready: it is sampled only in IDLE
    // (or in DONE with the loop option); Busy high means a request is ignored.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(HOLD_CYCLES - 1);

    state_t           state;
    logic [CNT_W-1:0] count;
    logic [5:0]       expected;
    logic [5:0]       diff;
    logic [5:0]       mask_next;

    // Golden truth table, bits 5..0 = XNOR, XOR, NOR, OR, NAND, AND
    always_comb begin
        expected = 6'h2A;
        case (Gate_In)
            2'b00:   expected = 6'h2A;
            2'b01:   expected = 6'h16;
            2'b10:   expected = 6'h16;
            default: expected = 6'h25;
        endcase
        diff      = Gate_Out ^ expected;
        mask_next = Err_Mask | diff;
    end

    assign dbg_state = state;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state    <= IDLE;
            count    <= '0;
            Gate_In  <= 2'b00;
            Busy     <= 1'b0;
            Done     <= 1'b0;
            Pass     <= 1'b0;
            Err_Mask <= 6'h00;
            Err_Vec  <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    Done <= 1'b0;
                    if (Start) begin
                        state    <= RUN;
                        Busy     <= 1'b1;
                        Gate_In  <= 2'b00;
                        count    <= '0;
                        Err_Mask <= 6'h00;
                        Err_Vec  <= 2'b00;
                        Pass     <= 1'b0;
                    end
                end
                RUN: begin
                    if (count == LAST) begin
                        // Compare at the edge closing the vector's last hold cycle
                        Err_Mask <= mask_next;
                        if (Err_Mask == 6'h00 && diff != 6'h00) begin
                            Err_Vec <= Gate_In;
                        end
                        count <= '0;
                        if (Gate_In != 2'b11) begin
                            Gate_In <= Gate_In + 2'd1;
                        end else begin
                            state   <= DONE;
                            Busy    <= 1'b0;
                            Done    <= 1'b1;
                            Gate_In <= 2'b00;
                            Pass    <= ~|mask_next;
                        end
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    Done <= 1'b0;
`ifdef GATE_SEQ_LOOP_EN
                    if (Start) begin
                        state   <= RUN;
                        Busy    <= 1'b1;
                        Gate_In <= 2'b00;
                        count   <= '0;
                    end else begin
                        state <= IDLE;
                    end
`else
                    state <= IDLE;
`endif
                end
                default: begin
                    state <= IDLE;
                    Busy  <= 1'b0;
                    Done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gate_seq_ctrl.sv
// Directed bench for gate_seq_ctrl: HOLD_CYCLES=4 main instance plus a HOLD_CYCLES=1 instance.
module tb_gate_seq_ctrl;

    logic       CLK;
    logic       RST;
    logic       Start, start2;
    logic [1:0] Gate_In, gate_in2;
    logic [5:0] Gate_Out, gate_out2;
    logic       Busy, busy2, Done, done2, Pass, pass2;
    logic [5:0] Err_Mask, err_mask2;
    logic [1:0] Err_Vec, err_vec2;
    logic [1:0] dbg_state, dbg_state2;
    logic [5:0] sa0, sa1, sa0_2, sa1_2;

    int vectors;
    int miscompares;

    gate_seq_ctrl #(.HOLD_CYCLES(4), .CNT_W(8)) dut (
        .CLK(CLK), .RST(RST), .Start(Start), .Gate_In(Gate_In), .Gate_Out(Gate_Out),
        .Busy(Busy), .Done(Done), .Pass(Pass), .Err_Mask(Err_Mask), .Err_Vec(Err_Vec),
        .dbg_state(dbg_state)
    );

    gate_seq_ctrl #(.HOLD_CYCLES(1), .CNT_W(2)) dut1 (
        .CLK(CLK), .RST(RST), .Start(start2), .Gate_In(gate_in2), .Gate_Out(gate_out2),
        .Busy(busy2), .Done(done2), .Pass(pass2), .Err_Mask(err_mask2), .Err_Vec(err_vec2),
        .dbg_state(dbg_state2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Gate datapath model built from the gate equations, with stuck-at fault injection
    function automatic logic [5:0] ideal(input logic [1:0] v);
        logic a, b;
        a = v[0];
        b = v[1];
        return {~(a ^ b), a ^ b, ~(a | b), a | b, ~(a & b), a & b};
    endfunction

    always_comb Gate_Out  = (ideal(Gate_In) & ~sa0) | sa1;
    always_comb gate_out2 = (ideal(gate_in2) & ~sa0_2) | sa1_2;

    task automatic pulse_start();
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (Done === 1'b1) begin
                ok = 1'b1;
                break;
            end
            @(negedge CLK);
        end
    endtask

    task automatic test_reset();
        RST = 1'b1;
        repeat (2) @(negedge CLK);
        vectors++;
        if ({Gate_In, Busy, Done, Pass, Err_Mask, Err_Vec, dbg_state} !== 15'h0) begin
            miscompares++;
            $display("FAIL reset_values: got gi=%0d busy=%b done=%b pass=%b mask=%h vec=%0d st=%0d, want all 0",
                     Gate_In, Busy, Done, Pass, Err_Mask, Err_Vec, dbg_state);
        end
        RST = 1'b0;
        @(negedge CLK);
    endtask

    task automatic test_clean_sweep();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            vectors++;
            if (Busy !== 1'b1 || Gate_In !== 2'(i / 4) || Done !== 1'b0) begin
                miscompares++;
                $display("FAIL clean_run cyc%0d: got busy=%b gi=%0d done=%b, want busy=1 gi=%0d done=0",
                         i, Busy, Gate_In, Done, i / 4);
            end
            @(negedge CLK);
        end
        vectors++;
        if (Done !== 1'b1 || Busy !== 1'b0 || Pass !== 1'b1 || Err_Mask !== 6'h00 ||
            Err_Vec !== 2'b00 || Gate_In !== 2'b00) begin
            miscompares++;
            $display("FAIL clean_done: got done=%b busy=%b pass=%b mask=%h vec=%0d gi=%0d, want 1 0 1 00 0 0",
                     Done, Busy, Pass, Err_Mask, Err_Vec, Gate_In);
        end
        @(negedge CLK);
        vectors++;
        if (Done !== 1'b0 || dbg_state !== 2'd0 || Pass !== 1'b1) begin
            miscompares++;
            $display("FAIL clean_after: got done=%b st=%0d pass=%b, want done=0 st=0 pass=1",
                     Done, dbg_state, Pass);
        end
    endtask

    task automatic test_stuck_xor();
        bit ok;
        sa0 = 6'h10;
        pulse_start();
        wait_done(ok);
        vectors++;
        if (!ok || Err_Mask !== 6'h10 || Err_Vec !== 2'b01 || Pass !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_xor: got ok=%b mask=%h vec=%0d pass=%b, want ok=1 mask=10 vec=1 pass=0",
                     ok, Err_Mask, Err_Vec, Pass);
        end
        sa0 = 6'h00;
        @(negedge CLK);
    endtask

    task automatic test_stuck_and_clear();
        bit ok;
        sa1 = 6'h01;
        pulse_start();
        wait_done(ok);
        vectors++;
        if (!ok || Err_Mask !== 6'h01 || Err_Vec !== 2'b00 || Pass !== 1'b0) begin
            miscompares++;
            $display("FAIL stuck_and: got ok=%b mask=%h vec=%0d pass=%b, want ok=1 mask=01 vec=0 pass=0",
                     ok, Err_Mask, Err_Vec, Pass);
        end
        sa1 = 6'h00;
        @(negedge CLK);
        vectors++;
        if (Err_Mask !== 6'h01 || Pass !== 1'b0) begin
            miscompares++;
            $display("FAIL flags_held_idle: got mask=%h pass=%b, want mask=01 pass=0", Err_Mask, Pass);
        end
        pulse_start();
        vectors++;
        if (Err_Mask !== 6'h00 || Err_Vec !== 2'b00 || Pass !== 1'b0 || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL flags_clear_on_start: got mask=%h vec=%0d pass=%b busy=%b, want 00 0 0 1",
                     Err_Mask, Err_Vec, Pass, Busy);
        end
        wait_done(ok);
        vectors++;
        if (!ok || Err_Mask !== 6'h00 || Pass !== 1'b1) begin
            miscompares++;
            $display("FAIL refault_sweep: got ok=%b mask=%h pass=%b, want ok=1 mask=00 pass=1",
                     ok, Err_Mask, Pass);
        end
        @(negedge CLK);
    endtask

    task automatic test_start_held();
        int busy_cnt, done_cnt;
        busy_cnt = 0;
        done_cnt = 0;
        Start = 1'b1;
        for (int i = 0; i < 30; i++) begin
            @(negedge CLK);
            if (Busy === 1'b1) busy_cnt++;
            if (Done === 1'b1) done_cnt++;
            Start = (i < 7) || (i == 9) || (i == 10);
        end
        vectors++;
        if (busy_cnt != 16 || done_cnt != 1 || dbg_state !== 2'd0 || Busy !== 1'b0) begin
            miscompares++;
            $display("FAIL start_held: got busy_cycles=%0d dones=%0d st=%0d busy=%b, want 16 1 0 0",
                     busy_cnt, done_cnt, dbg_state, Busy);
        end
    endtask

    task automatic test_reset_mid_run();
        int busy_cnt;
        pulse_start();
        repeat (5) @(negedge CLK);
        vectors++;
        if (Gate_In !== 2'b01 || Busy !== 1'b1) begin
            miscompares++;
            $display("FAIL pre_reset_run: got gi=%0d busy=%b, want gi=1 busy=1", Gate_In, Busy);
        end
        RST = 1'b1;
        #1;
        vectors++;
        if ({Gate_In, Busy, Done, Pass, Err_Mask, Err_Vec, dbg_state} !== 15'h0) begin
            miscompares++;
            $display("FAIL async_reset: got gi=%0d busy=%b done=%b pass=%b mask=%h vec=%0d st=%0d, want all 0",
                     Gate_In, Busy, Done, Pass, Err_Mask, Err_Vec, dbg_state);
        end
        @(negedge CLK);
        RST = 1'b0;
        @(negedge CLK);
        pulse_start();
        busy_cnt = 0;
        for (int i = 0; i < 100; i++) begin
            if (Busy !== 1'b1) break;
            busy_cnt++;
            @(negedge CLK);
        end
        vectors++;
        if (busy_cnt != 16 || Done !== 1'b1 || Pass !== 1'b1) begin
            miscompares++;
            $display("FAIL post_reset_sweep: got busy_cycles=%0d done=%b pass=%b, want 16 1 1",
                     busy_cnt, Done, Pass);
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        @(negedge CLK);
        Start = 1'b1;
        @(negedge CLK);
        Start = 1'b0;
        vectors++;
        if (Busy !== 1'b1 || Gate_In !== 2'b00 || Done !== 1'b0) begin
            miscompares++;
            $display("FAIL back_to_back: got busy=%b gi=%0d done=%b, want busy=1 gi=0 done=0",
                     Busy, Gate_In, Done);
        end
        wait_done(ok);
        vectors++;
        if (!ok || Pass !== 1'b1) begin
            miscompares++;
            $display("FAIL back_to_back_done: got ok=%b pass=%b, want 1 1", ok, Pass);
        end
        @(negedge CLK);
    endtask

    task automatic test_hold_one();
        start2 = 1'b1;
        @(negedge CLK);
        start2 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (busy2 !== 1'b1 || gate_in2 !== 2'(i)) begin
                miscompares++;
                $display("FAIL hold1_run cyc%0d: got busy=%b gi=%0d, want busy=1 gi=%0d", i, busy2, gate_in2, i);
            end
            @(negedge CLK);
        end
        vectors++;
        if (done2 !== 1'b1 || busy2 !== 1'b0 || pass2 !== 1'b1 || err_mask2 !== 6'h00) begin
            miscompares++;
            $display("FAIL hold1_done: got done=%b busy=%b pass=%b mask=%h, want 1 0 1 00",
                     done2, busy2, pass2, err_mask2);
        end
        @(negedge CLK);
    endtask

`ifdef GATE_SEQ_LOOP_EN
    task automatic test_loop();
        logic       exp_done;
        logic [1:0] exp_gi;
        sa1_2  = 6'h01;
        start2 = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            @(negedge CLK);
            if (i == 5) sa1_2 = 6'h00;
            exp_done = (i % 5 == 0);
            exp_gi   = exp_done ? 2'b00 : 2'((i % 5) - 1);
            vectors++;
            if (done2 !== exp_done || busy2 !== ~exp_done || gate_in2 !== exp_gi) begin
                miscompares++;
                $display("FAIL loop cyc%0d: got done=%b busy=%b gi=%0d, want done=%b busy=%b gi=%0d",
                         i, done2, busy2, gate_in2, exp_done, ~exp_done, exp_gi);
            end
        end
        vectors++;
        if (err_mask2 !== 6'h01 || err_vec2 !== 2'b00 || pass2 !== 1'b0) begin
            miscompares++;
            $display("FAIL loop_accumulate: got mask=%h vec=%0d pass=%b, want 01 0 0",
                     err_mask2, err_vec2, pass2);
        end
        start2 = 1'b0;
        repeat (2) @(negedge CLK);
    endtask
`endif

    initial begin
        vectors     = 0;
        miscompares = 0;
        Start       = 1'b0;
        start2      = 1'b0;
        sa0         = 6'h00;
        sa1         = 6'h00;
        sa0_2       = 6'h00;
        sa1_2       = 6'h00;
        RST         = 1'b1;
        test_reset();
        test_clean_sweep();
        test_stuck_xor();
        test_stuck_and_clear();
        test_start_held();
        test_reset_mid_run();
        test_back_to_back();
        test_hold_one();
`ifdef GATE_SEQ_LOOP_EN
        test_loop();
`endif
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
